// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl : parametrised interrupt controller in front of the MIPS core.
//
// Synchronises NUM_IRQ asynchronous request lines, latches them as edge- or
// level-mode pending bits, masks them per channel, and arbitrates by fixed
// priority (channel 0 highest). The winner is presented as irq_o / irq_id.
// In-service channels are tracked across the take (irq_ack) / return (irq_rti)
// pulses. Software configures the block through an 8-word register port.
//
// Optional feature macro: IRQ_CTRL_NEST_EN
//   defined   : a higher-priority channel may preempt one already in service.
//   undefined : a new interrupt is only presented while nothing is in service.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-low reset
//   irq_in     in   [NUM_IRQ] asynchronous request lines
//   irq_o      out  request to pipeline exception logic
//   irq_id     out  [ID_W] winning channel, 0 when irq_o==0
//   irq_ack    in   pulse: pipeline took the interrupt shown on irq_id
//   irq_rti    in   pulse: return-from-interrupt retired
//   reg_addr   in   [3] register word address
//   reg_we     in   register write strobe
//   reg_wdata  in   [32] register write data
//   reg_rdata  out  [32] register read data (combinational from reg_addr)
//
// Register map: 0 CTRL(bit0 GE) 1 MASK 2 MODE(1=edge) 3 PEND(W1C, edge only)
//               4 INSRV(ro) 5 VEC(ro, last acked id) 6,7 read 0
// -----------------------------------------------------------------------------
module irq_ctrl #(
  parameter int NUM_IRQ     = 8,
  parameter int ID_W        = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_o,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               irq_rti,
  input  logic [2:0]         reg_addr,
  input  logic               reg_we,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata
);

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] s_prev_q;
  logic               ge_q,    ge_d;
  logic [NUM_IRQ-1:0] mask_q,  mask_d;
  logic [NUM_IRQ-1:0] mode_q,  mode_d;
  logic [NUM_IRQ-1:0] pend_q,  pend_d;
  logic [NUM_IRQ-1:0] insrv_q, insrv_d;
  logic [ID_W-1:0]    vec_q,   vec_d;

  logic [NUM_IRQ-1:0] s, rise, cand, win_oh, top_oh, w1c, ack_clr, rti_clr;
  logic [NUM_IRQ-1:0] wdata_n, edge_next;
  logic [ID_W-1:0]    win_id;
  logic               allowed, take;
  logic               unused_wdata;

  assign s            = sync_q[SYNC_STAGES-1];
  assign wdata_n      = reg_wdata[NUM_IRQ-1:0];
  assign unused_wdata = ^reg_wdata;

  // ---------------------------------------------------------------------------
  // Arbitration. x & (~x + 1) isolates the lowest set bit, i.e. the
  // highest-priority channel. Because both operands are one-hot, comparing
  // them as unsigned numbers is the same as comparing channel indices.
  // ---------------------------------------------------------------------------
  assign cand   = pend_q & mask_q;
  assign win_oh = cand & (~cand + NUM_IRQ'(1));
  assign top_oh = insrv_q & (~insrv_q + NUM_IRQ'(1));

`ifdef IRQ_CTRL_NEST_EN
  assign allowed = (insrv_q == '0) || (win_oh < top_oh);
`else
  assign allowed = (insrv_q == '0);
`endif

  assign irq_o = ge_q & (cand != '0) & allowed;

  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (win_oh[i]) win_id = ID_W'(i);
    end
  end

  assign irq_id = irq_o ? win_id : '0;

  // ---------------------------------------------------------------------------
  // Take/return handshake: irq_ack is only honoured while irq_o is high (the
  // pipeline takes what it sees on irq_id); irq_rti retires the
  // highest-priority in-service channel. When both pulse together the return
  // is applied to the pre-ack INSRV and the take is OR-ed in afterwards.
  // ---------------------------------------------------------------------------
  assign take    = irq_ack & irq_o;
  assign rise    = s & ~s_prev_q;
  assign w1c     = (reg_we && reg_addr == 3'd3) ? wdata_n : '0;
  assign ack_clr = take ? win_oh : '0;
  assign rti_clr = irq_rti ? top_oh : '0;

  // A new edge in the same cycle as a clear wins, so no request is lost.
  assign edge_next = rise | (pend_q & ~(w1c | ack_clr));

  always_comb begin
    ge_d    = ge_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    if (reg_we && reg_addr == 3'd0) ge_d   = reg_wdata[0];
    if (reg_we && reg_addr == 3'd1) mask_d = wdata_n;
    if (reg_we && reg_addr == 3'd2) mode_d = wdata_n;
    // Level channels simply register the synchronised line.
    pend_d  = (mode_q & edge_next) | (~mode_q & s);
    insrv_d = (insrv_q & ~rti_clr) | (take ? win_oh : '0);
    vec_d   = take ? irq_id : vec_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_prev_q <= '0;
      ge_q     <= 1'b0;
      mask_q   <= '0;
      mode_q   <= '1;
      pend_q   <= '0;
      insrv_q  <= '0;
      vec_q    <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      // Edge history tracks s in every mode, so a level->edge switch on a
      // line that is already high does not see a spurious edge.
      s_prev_q <= s;
      ge_q     <= ge_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      insrv_q  <= insrv_d;
      vec_q    <= vec_d;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      3'd0:    reg_rdata = 32'(ge_q);
      3'd1:    reg_rdata = 32'(mask_q);
      3'd2:    reg_rdata = 32'(mode_q);
      3'd3:    reg_rdata = 32'(pend_q);
      3'd4:    reg_rdata = 32'(insrv_q);
      3'd5:    reg_rdata = 32'(vec_q);
      default: reg_rdata = '0;
    endcase
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller replacing the fixed 4-bit `interrupts` input path into the MIPS core.
- Synchronises NUM_IRQ external request lines and latches edge- or level-mode pending bits, with per-channel masking.
- Arbitrates by fixed priority (channel 0 highest) and presents one request plus an ID to the pipeline's exception logic.
- Tracks in-service channels across the take/return handshake (`irq_ack`/`irq_rti`); software configures it through a small memory-mapped register port.

Parameters:
- NUM_IRQ, 8, number of request channels, legal range 1..32.
- ID_W, 3, width of `irq_id`; must equal max(1, clog2(NUM_IRQ)).
- SYNC_STAGES, 2, synchroniser flops per input, legal range 2..3.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a clk edge resets all state.
- irq_in  in  NUM_IRQ  asynchronous external request lines.
- irq_o  out  1  request to the pipeline exception logic.
- irq_id  out  ID_W  winning channel number; valid while irq_o==1.
- irq_ack  in  1  one-cycle pulse: the pipeline has taken the interrupt shown on irq_id.
- irq_rti  in  1  one-cycle pulse: return-from-interrupt retired.
- reg_addr  in  3  word address of the register port.
- reg_we  in  1  register write strobe.
- reg_wdata  in  32  register write data.
- reg_rdata  out  32  register read data, combinational from reg_addr.

Behaviour:
- Registers (unused upper bits read 0, writes to them ignored):
  - 0 CTRL: bit0 = global enable (GE).
  - 1 MASK: 1 = channel enabled.
  - 2 MODE: 1 = edge, 0 = level.
  - 3 PEND: read pending; write-1-to-clear, edge channels only.
  - 4 INSRV: read-only.
  - 5 VEC: read-only, last acked ID.
  - 6,7: read 0, writes ignored.
- Reset values: CTRL=0, MASK=0, MODE=all 1s, PEND=0, INSRV=0, VEC=0, synchroniser and edge-history flops=0. Hence irq_o=0 and irq_id=0 out of reset.
- Synchroniser: SYNC_STAGES flops per channel; s[i] is the last stage.
- Edge channel: PEND[i] sets on a 0->1 transition of s[i]. It clears on W1C or on irq_ack with irq_id==i.
- Set priority: if a set and a clear occur in the same cycle, set wins and PEND stays 1.
- Level channel: PEND[i] = s[i], registered each cycle. W1C and ack do not affect it.
- Latency: irq_in rises just before edge 0 → PEND set at edge SYNC_STAGES → irq_o high in that same cycle (irq_o is combinational from registers).
- Arbitration (combinational):
  - cand = PEND & MASK.
  - w = lowest set bit of cand.
  - top = lowest set bit of INSRV (none if INSRV==0).
  - irq_o = GE & (cand!=0) & (INSRV==0 or w<top).
  - irq_id = w when irq_o==1, else 0.
- irq_ack when irq_o==1: set INSRV[irq_id], set VEC=irq_id, clear PEND[irq_id] if the channel is in edge mode.
- irq_ack when irq_o==0: ignored, no state change.
- irq_rti: clear the lowest set bit of INSRV. Ignored if INSRV==0.
- irq_ack and irq_rti in the same cycle: irq_rti applies first, using INSRV before the ack. The ack uses the irq_id/irq_o values present in that cycle.
- MASK or GE cleared while irq_o==1: irq_o drops the next cycle; PEND is retained.
- MODE change 1→0 on a channel: PEND follows s[i] from the next edge. MODE change 0→1: PEND is held, with no spurious edge.
- Register write and hardware update to the same register in the same cycle: the hardware update wins for PEND set/INSRV/VEC.
- Reset mid-service: all state returns to reset values, including INSRV.

Optional Feature:
- Macro IRQ_CTRL_NEST_EN.
- Defined: the preemption rule above applies. A higher-priority channel (w<top) raises irq_o while a lower one is in service.
- Undefined: irq_o additionally requires INSRV==0, so there is no nesting. INSRV then holds at most one bit, and irq_rti clears it.

Test Plan:
- Reset, then write CTRL=1, MASK=0x04, MODE=0xFF; pulse irq_in[2] for 1 cycle → PEND=0x04 and irq_o=1, irq_id=2 exactly SYNC_STAGES edges later. Pulse irq_ack → PEND=0, INSRV=0x04, VEC=2, irq_o=0.
- Level mode: MODE=0, MASK=0x01; hold irq_in[0]=1 → irq_o=1. Write PEND=0x01 → PEND stays 1. Drop irq_in[0] → irq_o=0 after SYNC_STAGES+1 edges.
- Priority: channels 5 and 1 pending together, both unmasked → irq_id=1. After ack, with nesting off → irq_o=0 until irq_rti, then irq_id=5.
- With IRQ_CTRL_NEST_EN: ack channel 5 (INSRV=0x20), then raise channel 1 → irq_o=1, irq_id=1. Raise channel 6 instead → irq_o=0. Two irq_rti pulses → INSRV 0x22→0x20→0x00.
- Same-cycle: a new edge on channel 3 arrives in the ack cycle for channel 3 → PEND[3]=1 afterwards. Simultaneous irq_ack(ch 1) and irq_rti with INSRV=0x08, nesting enabled → INSRV=0x02.
- Drive reset=0 for one edge with INSRV=0x05, PEND=0x0A → all registers return to reset values; irq_o=0, reg_rdata of MODE=all 1s.
